// File: rtl/board_eval.sv
// board_eval: scores N contiguous 64-square candidate boards fetched from
// SDRAM and reports the best one for the configured side.
// Optional feature: define BOARD_EVAL_CENTRE_EN to add a +/-1 bonus for any
// piece standing on one of the four centre squares (offsets 27, 28, 35, 36).
//
// Handshakes: the CPU port is a wait-state slave. A command is taken on
// a clock edge where a strobe is high and slave_waitrequest is 0. The SDRAM
// port is a pipelined master with one read outstanding. A request is taken
// on an edge where master_read=1 and master_waitrequest=0. Address and
// strobe are held until then. Data is accepted on any edge where
// master_readdatavalid=1, but only in RD_WAIT.
module board_eval (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CMP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [31:0]        r_src;
  logic [7:0]         r_n;
  logic               r_side;       // 1 = black (minimise), 0 = white (maximise)
  logic [7:0]         r_b;          // current board index == boards evaluated so far
  logic [5:0]         r_s;          // current square
  logic signed [15:0] r_acc;
  logic [31:0]        r_best_idx;
  logic signed [15:0] r_best_score;

  logic               w_start;
  logic               w_last_board;
  logic               w_better;
  logic [13:0]        w_word_idx;
  logic [7:0]         w_sq;
  logic [7:0]         w_mag;
  logic [15:0]        w_piece;
  logic signed [15:0] w_sq_score;
  logic               w_unused;

  assign w_start      = slave_write && (slave_address == 4'd0);
  assign w_last_board = ({1'b0, r_b} + 9'd1) == {1'b0, r_n};
  assign w_better     = r_side ? (r_acc < r_best_score) : (r_acc > r_best_score);
  assign w_word_idx   = {r_b, r_s};
  assign w_unused     = ^master_readdata[31:8];
  assign o_dbg_state  = r_state;

  // Square decode: signed byte, magnitude picks the piece value.
  assign w_sq  = master_readdata[7:0];
  assign w_mag = w_sq[7] ? (8'd0 - w_sq) : w_sq;

  // Piece value lookup; magnitudes outside 1..6 (including -128) are worth 0.
  always_comb begin
    w_piece = 16'd0;
    case (w_mag)
      8'd1:    w_piece = 16'd1;
      8'd2:    w_piece = 16'd3;
      8'd3:    w_piece = 16'd3;
      8'd4:    w_piece = 16'd5;
      8'd5:    w_piece = 16'd9;
      8'd6:    w_piece = 16'd100;
      default: w_piece = 16'd0;
    endcase
  end

  // Signed contribution of the incoming square, with optional centre bonus.
  always_comb begin
    w_sq_score = w_sq[7] ? $signed(16'd0 - w_piece) : $signed(w_piece);
`ifdef BOARD_EVAL_CENTRE_EN
    if ((w_sq != 8'd0) &&
        (r_s == 6'd27 || r_s == 6'd28 || r_s == 6'd35 || r_s == 6'd36))
      w_sq_score = w_sq_score + (w_sq[7] ? -16'sd1 : 16'sd1);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next            = r_state;
    slave_waitrequest = 1'b1;
    master_read       = 1'b0;
    case (r_state)
      S_IDLE: begin
        slave_waitrequest = 1'b0;
        if (w_start) w_next = (r_n == 8'd0) ? S_DONE : S_RD_REQ;
      end
      S_RD_REQ: begin
        master_read = 1'b1;
        if (!master_waitrequest) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (master_readdatavalid) w_next = (r_s == 6'd63) ? S_CMP : S_RD_REQ;
      end
      S_CMP: begin
        w_next = w_last_board ? S_DONE : S_RD_REQ;
      end
      S_DONE: begin
        slave_waitrequest = 1'b0;
        if (slave_read && slave_address == 4'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!rst_n) slave_waitrequest = 1'b1;
  end

  // SDRAM word address; byte offset (b*64+s)*4 wraps modulo 2^32.
  always_comb begin
    master_address = 32'd0;
    if (r_state == S_RD_REQ) master_address = r_src + {16'd0, w_word_idx, 2'b00};
  end

  // Configuration registers, scoring accumulator and best-board tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src        <= 32'd0;
      r_n          <= 8'd0;
      r_side       <= 1'b0;
      r_b          <= 8'd0;
      r_s          <= 6'd0;
      r_acc        <= 16'sd0;
      r_best_idx   <= 32'hFFFF_FFFF;
      r_best_score <= 16'sd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                r_acc        <= 16'sd0;
                r_b          <= 8'd0;
                r_s          <= 6'd0;
                r_best_idx   <= 32'hFFFF_FFFF;
                r_best_score <= r_side ? 16'sh7FFF : 16'sh8000;
              end
              4'd1:    r_src  <= slave_writedata;
              4'd2:    r_n    <= slave_writedata[7:0];
              4'd3:    r_side <= slave_writedata[31];
              default: ;
            endcase
          end
        end
        S_RD_WAIT: begin
          if (master_readdatavalid) begin
            r_acc <= r_acc + w_sq_score;
            r_s   <= r_s + 6'd1;       // wraps to 0 after the last square
          end
        end
        S_CMP: begin
          // Strict comparison: ties keep the earlier board.
          if (w_better) begin
            r_best_score <= r_acc;
            r_best_idx   <= {24'd0, r_b};
          end
          r_b   <= r_b + 8'd1;
          r_acc <= 16'sd0;
        end
        default: ;
      endcase
    end
  end

  // CPU readback, valid in every state.
  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      4'd0:    slave_readdata = r_best_idx;
      4'd1:    slave_readdata = {{16{r_best_score[15]}}, r_best_score};
      4'd2:    slave_readdata = {24'd0, r_b};
      default: slave_readdata = 32'd0;
    endcase
  end

endmodule
